// File: rtl/jtframe_dump_ctrl.sv
// Frame-dump capture controller: counts frames on the vs falling edge and opens a
// capture window at a start frame (or on a manual trigger) for a fixed number of frames.
module jtframe_dump_ctrl #(
    parameter logic [31:0] START_FRAME = 32'd0,
    parameter logic [31:0] LEN_FRAMES  = 32'd1,
    parameter int          USE_DL      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs,
    input  logic        downloading,
    input  logic        trig,
    input  logic        abort,
    input  logic        rearm,
    output logic [31:0] frame_cnt,
    output logic        capture_en,
    output logic        capture_start,
    output logic        capture_done,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        WAIT_DL = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3
    } state_t;

    localparam logic   DL_EN     = (USE_DL != 0);
    localparam state_t RST_STATE = DL_EN ? WAIT_DL : ARMED;

    state_t      st, st_next;
    logic        vs_l, dl_l;
    logic [31:0] len_cnt;
    logic        vsf, dlf, dlr, len_end;

    assign vsf     = vs_l & ~vs;
    assign dlf     = DL_EN & dl_l & ~downloading;
    assign dlr     = DL_EN & ~dl_l & downloading;
    assign len_end = vsf && (LEN_FRAMES != 32'd0) && (len_cnt + 32'd1 == LEN_FRAMES);
    assign state   = st;

    // Priority: dlr > abort > length end > trig > frame match.
    always_comb begin
        st_next = st;
        case (st)
            WAIT_DL: if (!DL_EN || dlf) st_next = ARMED;
            ARMED:   if (trig || (vsf && frame_cnt == START_FRAME)) st_next = CAPTURE;
            CAPTURE: if (abort || len_end) st_next = DONE;
            DONE:    if (rearm) st_next = ARMED;
            default: st_next = WAIT_DL;
        endcase
        if (dlr) st_next = WAIT_DL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= RST_STATE;
            vs_l          <= 1'b0;
            dl_l          <= 1'b0;
            frame_cnt     <= 32'd0;
            len_cnt       <= 32'd0;
            capture_en    <= 1'b0;
            capture_start <= 1'b0;
            capture_done  <= 1'b0;
        end else begin
            st   <= st_next;
            vs_l <= vs;
            dl_l <= downloading;
            // A download ending restarts the frame numbering, even on a frame edge.
            if (dlf)
                frame_cnt <= 32'd0;
            else if (vsf)
                frame_cnt <= frame_cnt + 32'd1;
            else
                frame_cnt <= frame_cnt;
            if (st != CAPTURE)
                len_cnt <= 32'd0;
            else if (vsf)
                len_cnt <= len_cnt + 32'd1;
            capture_en    <= (st_next == CAPTURE);
            capture_start <= (st_next == CAPTURE) && (st != CAPTURE);
            capture_done  <= (st == CAPTURE) && (st_next != CAPTURE);
        end
    end

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Directed bench for jtframe_dump_ctrl: three instances with different parameters,
// start/done pulses checked against an expected-event queue.
module tb_jtframe_dump_ctrl;

    localparam int W = 36;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  vs = '0, dl = '0, trig = '0, abort = '0, rearm = '0;
    logic [31:0] fc [3];
    logic [2:0]  st [3];
    logic [2:0]  en, cs, cd;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_obs;
    int checks = 0;
    int passed = 0;

    jtframe_dump_ctrl #(.START_FRAME(32'd3), .LEN_FRAMES(32'd2), .USE_DL(1)) dut_a (
        .clk(clk), .rst(rst), .vs(vs[0]), .downloading(dl[0]), .trig(trig[0]),
        .abort(abort[0]), .rearm(rearm[0]), .frame_cnt(fc[0]), .capture_en(en[0]),
        .capture_start(cs[0]), .capture_done(cd[0]), .state(st[0]));

    jtframe_dump_ctrl #(.START_FRAME(32'd0), .LEN_FRAMES(32'd0), .USE_DL(1)) dut_b (
        .clk(clk), .rst(rst), .vs(vs[1]), .downloading(dl[1]), .trig(trig[1]),
        .abort(abort[1]), .rearm(rearm[1]), .frame_cnt(fc[1]), .capture_en(en[1]),
        .capture_start(cs[1]), .capture_done(cd[1]), .state(st[1]));

    jtframe_dump_ctrl #(.START_FRAME(32'hFFFF_FFFF), .LEN_FRAMES(32'd1), .USE_DL(0)) dut_c (
        .clk(clk), .rst(rst), .vs(vs[2]), .downloading(dl[2]), .trig(trig[2]),
        .abort(abort[2]), .rearm(rearm[2]), .frame_cnt(fc[2]), .capture_en(en[2]),
        .capture_start(cs[2]), .capture_done(cd[2]), .state(st[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int i);
        vs[i] = 1'b1;
        tick(2);
        vs[i] = 1'b0;
        tick(2);
    endtask

    task automatic dl_pulse(input int i);
        dl[i] = 1'b1;
        tick(2);
        dl[i] = 1'b0;
        tick(2);
    endtask

    // which: 0 = trig, 1 = abort, 2 = rearm
    task automatic pulse(input int which, input int i);
        case (which)
            0:       trig[i]  = 1'b1;
            1:       abort[i] = 1'b1;
            default: rearm[i] = 1'b1;
        endcase
        tick(1);
        trig[i] = 1'b0;
        abort[i] = 1'b0;
        rearm[i] = 1'b0;
        tick(1);
    endtask

    // Event word: {instance, done, start, frame_cnt in the pulse cycle}
    task automatic push(input int i, input logic done, input logic [31:0] f);
        logic [1:0] idx;
        idx = 2'(i);
        exp_q.push_back({idx, done, ~done, f});
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cs[i] || cd[i]) begin
                mon_obs = {2'(i), cd[i], cs[i], fc[i]};
                if (exp_q.size() == 0) begin
                    checks++;
                    $error("FAIL unexpected_event: got %0h expected none", mon_obs);
                end else begin
                    chk("event", {28'd0, mon_obs}, {28'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        tick(3);
        chk("rst_state_a", st[0], 3'd0);
        chk("rst_state_b", st[1], 3'd0);
        chk("rst_state_c", st[2], 3'd1);
        chk("rst_fc_a", fc[0], 32'd0);
        chk("rst_en", en, 3'b000);
        rst = 1'b0;
        tick(2);

        // Download end, then six frames: start on the 4th, done on the 6th
        dl_pulse(0);
        chk("dlf_armed", st[0], 3'd1);
        chk("dlf_fc", fc[0], 32'd0);
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) push(0, 1'b0, 32'd4);
            if (k == 6) push(0, 1'b1, 32'd6);
            frame(0);
            chk("fc_count", fc[0], 32'(k));
            chk("en_window", {63'd0, en[0]}, {63'd0, (k == 4 || k == 5)});
        end
        chk("len_done_state", st[0], 3'd3);

        pulse(2, 0);
        chk("rearm_state", st[0], 3'd1);
        chk("rearm_fc_kept", fc[0], 32'd6);

        // Manual trigger at frame_cnt=1, away from START_FRAME
        dl_pulse(0);
        frame(0);
        chk("trig_fc", fc[0], 32'd1);
        push(0, 1'b0, 32'd1);
        pulse(0, 0);
        chk("trig_capture", st[0], 3'd2);
        chk("trig_en", en[0], 1'b1);

        // Abort coinciding with the length-ending frame: a single done pulse
        frame(0);
        push(0, 1'b1, 32'd3);
        vs[0] = 1'b1;
        tick(2);
        vs[0] = 1'b0;
        abort[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        tick(3);
        chk("abort_len_state", st[0], 3'd3);
        chk("abort_len_en", en[0], 1'b0);

        // Reset in the middle of a capture drops the window without a done pulse
        pulse(2, 0);
        push(0, 1'b0, 32'd3);
        pulse(0, 0);
        chk("pre_rst_en", en[0], 1'b1);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_en", en[0], 1'b0);
        chk("rst_mid_state", st[0], 3'd0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Download restarting during capture
        dl_pulse(0);
        push(0, 1'b0, 32'd0);
        pulse(0, 0);
        frame(0);
        chk("cap_fc", fc[0], 32'd1);
        chk("cap_en", en[0], 1'b1);
        push(0, 1'b1, 32'd1);
        dl[0] = 1'b1;
        tick(2);
        chk("dlr_state", st[0], 3'd0);
        chk("dlr_en", en[0], 1'b0);
        frame(0);
        chk("dl_fc", fc[0], 32'd2);
        vs[0] = 1'b1;
        tick(2);
        vs[0] = 1'b0;
        dl[0] = 1'b0;
        tick(2);
        chk("dlf_vsf_fc", fc[0], 32'd0);
        chk("dlf_vsf_state", st[0], 3'd1);

        // Unlimited length: stays open until abort
        dl_pulse(1);
        chk("b_armed", st[1], 3'd1);
        push(1, 1'b0, 32'd1);
        frame(1);
        chk("b_en", en[1], 1'b1);
        for (int k = 0; k < 100; k++) frame(1);
        chk("b_en_100", en[1], 1'b1);
        chk("b_state_100", st[1], 3'd2);
        chk("b_fc_101", fc[1], 32'd101);
        push(1, 1'b1, 32'd101);
        pulse(1, 1);
        chk("b_abort_en", en[1], 1'b0);
        chk("b_abort_state", st[1], 3'd3);
        pulse(2, 1);
        pulse(1, 1);
        chk("b_abort_ignored", st[1], 3'd1);

        // No download gating; start frame at the top of the counter range
        dl[2] = 1'b1;
        tick(2);
        chk("c_dl_ignored", st[2], 3'd1);
        dl[2] = 1'b0;
        tick(2);
        frame(2);
        chk("c_fc1", fc[2], 32'd1);
        force dut_c.frame_cnt = 32'hFFFF_FFFE;
        tick(1);
        release dut_c.frame_cnt;
        tick(1);
        chk("c_preload", fc[2], 32'hFFFF_FFFE);
        frame(2);
        chk("c_fc_max", fc[2], 32'hFFFF_FFFF);
        chk("c_not_started", st[2], 3'd1);
        push(2, 1'b0, 32'd0);
        frame(2);
        chk("c_wrap_fc", fc[2], 32'd0);
        chk("c_wrap_state", st[2], 3'd2);
        push(2, 1'b1, 32'd1);
        frame(2);
        chk("c_done_state", st[2], 3'd3);

        tick(3);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
